// File: rtl/cache_stats_monitor_if.sv
// Bus bundle for cache_stats_monitor: event inputs, snapshot/clear controls,
// registered read port and sticky protocol-error flags.
//   master : drives events/controls/read requests, observes read results
//   slave  : the monitor itself
interface cache_stats_monitor_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CNT_W  = 32
) ();
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              enable;
  logic [NUM_CH-1:0] ev_read;
  logic [NUM_CH-1:0] ev_write;
  logic [NUM_CH-1:0] ev_hit;
  logic [NUM_CH-1:0] ev_evict;
  logic              snap;
  logic              clr;
  logic              rd_req;
  logic [CH_W-1:0]   rd_ch;
  logic [2:0]        rd_sel;
  logic              rd_valid;
  logic [CNT_W-1:0]  rd_data;
  logic              rd_err;
  logic [NUM_CH-1:0] proto_err;

  modport master (
    output enable, ev_read, ev_write, ev_hit, ev_evict, snap, clr,
    output rd_req, rd_ch, rd_sel,
    input  rd_valid, rd_data, rd_err, proto_err
  );

  modport slave (
    input  enable, ev_read, ev_write, ev_hit, ev_evict, snap, clr,
    input  rd_req, rd_ch, rd_sel,
    output rd_valid, rd_data, rd_err, proto_err
  );
endinterface

// File: rtl/cache_stats_monitor.sv
// Per-channel cache statistics monitor: saturating read/write/hit/evict
// counters, atomic snapshot into a shadow bank, clear, and a one-cycle
// registered read port onto the shadow bank plus a live status word.
// Ports:
//   clock  - system clock, posedge
//   reset  - synchronous, active-high
//   bus    - cache_stats_monitor_if slave (events, snap/clr, read port,
//            proto_err)
module cache_stats_monitor #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CNT_W  = 32
) (
  input logic                  clock,
  input logic                  reset,
  cache_stats_monitor_if.slave bus
);
  // Counter index order: 0=reads 1=writes 2=hits 3=evicts
  localparam int unsigned    NUM_K      = 4;
  localparam logic [2:0]     SEL_STATUS = 3'd4;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [CNT_W-1:0] live_q   [NUM_CH][NUM_K];
  logic [CNT_W-1:0] live_d   [NUM_CH][NUM_K];
  logic [CNT_W-1:0] shadow_q [NUM_CH][NUM_K];
  logic [CNT_W-1:0] shadow_d [NUM_CH][NUM_K];
  logic [NUM_K-1:0] sat_q    [NUM_CH];
  logic [NUM_K-1:0] sat_d    [NUM_CH];
  logic [NUM_CH-1:0] proto_q;
  logic [NUM_CH-1:0] proto_d;

  logic             rd_valid_q;
  logic             rd_valid_d;
  logic [CNT_W-1:0] rd_data_q;
  logic [CNT_W-1:0] rd_data_d;
  logic             rd_err_q;
  logic             rd_err_d;

  logic [NUM_K-1:0]  ev       [NUM_CH];
  logic [NUM_CH-1:0] orphan_hit;
  logic [31:0]       ch_ext;
  logic              ch_ok;
  logic              sel_ok;
  logic [CNT_W-1:0]  sel_word;

  // Gate events with enable; flag hits that arrive without an access
  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      ev[c] = {bus.ev_evict[c], bus.ev_hit[c], bus.ev_write[c], bus.ev_read[c]}
              & {NUM_K{bus.enable}};
      orphan_hit[c] = bus.enable & bus.ev_hit[c] & ~bus.ev_read[c] & ~bus.ev_write[c];
    end
  end

  // Live counter update, saturation, clear and snapshot
  always_comb begin
    live_d   = live_q;
    shadow_d = shadow_q;
    sat_d    = sat_q;
    proto_d  = proto_q;

    // Shadow captures pre-update live values, unaffected by clr
    if (bus.snap) begin
      shadow_d = live_q;
    end

    for (int unsigned c = 0; c < NUM_CH; c++) begin
      for (int unsigned k = 0; k < NUM_K; k++) begin
        if (bus.clr) begin
          // Clear discards history but this cycle's event still counts
          live_d[c][k] = CNT_W'(ev[c][k]);
        end else if (ev[c][k]) begin
          if (live_q[c][k] == CNT_MAX) begin
            sat_d[c][k] = 1'b1;
          end else begin
            live_d[c][k] = live_q[c][k] + CNT_W'(1);
          end
        end
      end
      if (bus.clr) begin
        sat_d[c] = '0;
      end
    end

    if (bus.clr) begin
      proto_d = '0;
    end else begin
      proto_d = proto_q | orphan_hit;
    end
  end

  // Read port: select shadow counter or live status word
  always_comb begin
    rd_valid_d = bus.rd_req;
    rd_data_d  = '0;
    rd_err_d   = 1'b0;
    sel_word   = '0;
    ch_ext     = 32'(bus.rd_ch);
    ch_ok      = ch_ext < 32'(NUM_CH);
    sel_ok     = bus.rd_sel <= SEL_STATUS;

    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (ch_ext == 32'(c)) begin
        for (int unsigned k = 0; k < NUM_K; k++) begin
          if (bus.rd_sel == 3'(k)) begin
            sel_word = shadow_q[c][k];
          end
        end
        if (bus.rd_sel == SEL_STATUS) begin
          sel_word = CNT_W'({proto_q[c], sat_q[c]});
        end
      end
    end

    if (bus.rd_req) begin
      if (ch_ok && sel_ok) begin
        rd_data_d = sel_word;
      end else begin
        rd_err_d = 1'b1;
      end
    end
  end

  // State registers
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        for (int unsigned k = 0; k < NUM_K; k++) begin
          live_q[c][k]   <= '0;
          shadow_q[c][k] <= '0;
        end
        sat_q[c] <= '0;
      end
      proto_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_err_q   <= 1'b0;
    end else begin
      live_q     <= live_d;
      shadow_q   <= shadow_d;
      sat_q      <= sat_d;
      proto_q    <= proto_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_err_q   <= rd_err_d;
    end
  end

  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_err    = rd_err_q;
  assign bus.proto_err = proto_q;

endmodule

// File: tb/tb_cache_stats_monitor.sv
// Directed testbench for cache_stats_monitor with a read-result scoreboard.
module tb_cache_stats_monitor;
  logic clk;
  logic rst;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  cache_stats_monitor_if #(.NUM_CH(2), .CNT_W(8)) bus0 ();
  cache_stats_monitor_if #(.NUM_CH(3), .CNT_W(8)) bus1 ();

  cache_stats_monitor #(.NUM_CH(2), .CNT_W(8)) u_dut0 (
    .clock (clk),
    .reset (rst),
    .bus   (bus0.slave)
  );

  cache_stats_monitor #(.NUM_CH(3), .CNT_W(8)) u_dut1 (
    .clock (clk),
    .reset (rst),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_pulses();
    bus0.ev_read = '0; bus0.ev_write = '0; bus0.ev_hit = '0; bus0.ev_evict = '0;
    bus0.snap = 1'b0; bus0.clr = 1'b0; bus0.rd_req = 1'b0;
    bus0.rd_ch = '0; bus0.rd_sel = '0;
    bus1.ev_read = '0; bus1.ev_write = '0; bus1.ev_hit = '0; bus1.ev_evict = '0;
    bus1.snap = 1'b0; bus1.clr = 1'b0; bus1.rd_req = 1'b0;
    bus1.rd_ch = '0; bus1.rd_sel = '0;
  endtask

  task automatic issue0(input int ch, input int sel, input int data, input logic err);
    bus0.rd_req = 1'b1;
    bus0.rd_ch  = 1'(ch);
    bus0.rd_sel = 3'(sel);
    q0.push_back('{data: 32'(data), err: err});
  endtask

  task automatic issue1(input int ch, input int sel, input int data, input logic err);
    bus1.rd_req = 1'b1;
    bus1.rd_ch  = 2'(ch);
    bus1.rd_sel = 3'(sel);
    q1.push_back('{data: 32'(data), err: err});
  endtask

  // Advance one clock, check the read ports against the scoreboard, then
  // drop all single-cycle pulses.
  task automatic tick();
    logic pre0, pre1, drop0, drop1;
    exp_t e;
    pre0  = bus0.rd_req && !rst;
    drop0 = bus0.rd_req && rst;
    pre1  = bus1.rd_req && !rst;
    drop1 = bus1.rd_req && rst;
    @(posedge clk);
    #1;
    if (drop0 && q0.size() > 0) e = q0.pop_front();
    if (drop1 && q1.size() > 0) e = q1.pop_front();

    chk("rd_valid0", 32'(bus0.rd_valid), 32'(pre0));
    if (pre0 && q0.size() > 0) begin
      e = q0.pop_front();
      chk("rd_data0", 32'(bus0.rd_data), e.data);
      chk("rd_err0", 32'(bus0.rd_err), 32'(e.err));
    end else begin
      chk("rd_data0_idle", 32'(bus0.rd_data), 32'd0);
      chk("rd_err0_idle", 32'(bus0.rd_err), 32'd0);
    end

    chk("rd_valid1", 32'(bus1.rd_valid), 32'(pre1));
    if (pre1 && q1.size() > 0) begin
      e = q1.pop_front();
      chk("rd_data1", 32'(bus1.rd_data), e.data);
      chk("rd_err1", 32'(bus1.rd_err), 32'(e.err));
    end else begin
      chk("rd_data1_idle", 32'(bus1.rd_data), 32'd0);
      chk("rd_err1_idle", 32'(bus1.rd_err), 32'd0);
    end
    clear_pulses();
  endtask

  initial begin
    rst = 1'b1;
    bus0.enable = 1'b1;
    bus1.enable = 1'b1;
    clear_pulses();
    tick();
    tick();
    chk("reset_proto0", 32'(bus0.proto_err), 32'd0);
    rst = 1'b0;

    // 1: mixed traffic on both channels, snapshot, read back
    for (int i = 0; i < 10; i++) begin
      bus0.ev_read  = 2'b01;
      bus0.ev_hit   = (i < 6) ? 2'b01 : 2'b00;
      bus0.ev_write = (i < 3) ? 2'b10 : 2'b00;
      bus0.ev_evict = (i < 2) ? 2'b10 : 2'b00;
      tick();
    end
    bus0.snap = 1'b1; tick();
    issue0(0, 0, 10, 1'b0); tick();
    issue0(0, 2, 6, 1'b0);  tick();
    issue0(1, 1, 3, 1'b0);  tick();
    issue0(1, 3, 2, 1'b0);  tick();
    issue0(0, 1, 0, 1'b0);  tick();
    issue0(1, 4, 0, 1'b0);  tick();
    tick();
    chk("t1_proto", 32'(bus0.proto_err), 32'd0);

    // 2: saturation at 8 bits
    bus0.clr = 1'b1; tick();
    for (int i = 0; i < 300; i++) begin
      bus0.ev_read = 2'b01;
      tick();
    end
    bus0.snap = 1'b1; tick();
    issue0(0, 0, 255, 1'b0); tick();
    issue0(0, 4, 1, 1'b0);   tick();
    issue0(0, 2, 0, 1'b0);   tick();
    issue0(1, 0, 0, 1'b0);   tick();
    tick();

    // 3: clr+snap with an event in the same cycle; read concurrent with snap
    bus0.clr = 1'b1; tick();
    for (int i = 0; i < 5; i++) begin
      bus0.ev_read = 2'b01;
      tick();
    end
    bus0.clr = 1'b1; bus0.ev_read = 2'b01; bus0.snap = 1'b1; tick();
    issue0(0, 0, 5, 1'b0); tick();
    bus0.snap = 1'b1; issue0(0, 0, 5, 1'b0); tick();
    issue0(0, 0, 1, 1'b0); tick();
    issue0(0, 4, 0, 1'b0); tick();
    tick();

    // 4: orphan hit sets sticky proto_err, clr removes it
    bus0.clr = 1'b1; tick();
    bus0.ev_hit = 2'b10; tick();
    chk("t4_proto_set", 32'(bus0.proto_err), 32'h2);
    tick();
    chk("t4_proto_sticky", 32'(bus0.proto_err), 32'h2);
    bus0.snap = 1'b1; tick();
    issue0(1, 2, 1, 1'b0);     tick();
    issue0(1, 4, 'h10, 1'b0);  tick();
    issue0(0, 4, 0, 1'b0);     tick();
    bus0.clr = 1'b1; tick();
    chk("t4_proto_clr", 32'(bus0.proto_err), 32'h0);

    // 5: bad selector / bad channel
    issue0(1, 5, 0, 1'b1); tick();
    issue0(0, 7, 0, 1'b1); tick();
    issue1(3, 0, 0, 1'b1); tick();
    issue1(2, 0, 0, 1'b0); tick();
    issue1(2, 4, 0, 1'b0); tick();
    tick();

    // 6: enable=0 ignores events; reset drops in-flight read
    bus0.clr = 1'b1; tick();
    bus0.enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus0.ev_read = 2'b01;
      bus0.ev_hit  = 2'b10;
      tick();
    end
    bus0.enable = 1'b1;
    chk("t6_proto_disabled", 32'(bus0.proto_err), 32'h0);
    bus0.snap = 1'b1; tick();
    issue0(0, 0, 0, 1'b0); tick();
    issue0(1, 2, 0, 1'b0); tick();
    for (int i = 0; i < 3; i++) begin
      bus0.ev_read = 2'b01;
      tick();
    end
    bus0.ev_hit = 2'b01; tick();
    chk("t6_proto_pre_rst", 32'(bus0.proto_err), 32'h1);
    bus0.snap = 1'b1; tick();
    issue0(0, 0, 3, 1'b0); tick();
    rst = 1'b1;
    issue0(0, 0, 3, 1'b0); tick();
    rst = 1'b0;
    chk("t6_proto_rst", 32'(bus0.proto_err), 32'h0);
    issue0(0, 0, 0, 1'b0); tick();
    bus0.snap = 1'b1; tick();
    issue0(0, 0, 0, 1'b0); tick();
    issue0(0, 2, 0, 1'b0); tick();
    issue0(0, 4, 0, 1'b0); tick();
    tick();

    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
